// File: rtl/fp_job_sequencer_if.sv
// Bundle of the request/response handshakes, the core control lines and the
// shared byte-wide data-memory port used by fp_job_sequencer.
interface fp_job_sequencer_if #(
    parameter int unsigned CNT_W = 16
);
    // Job request
    logic              req_valid;
    logic              req_ready;
    logic [15:0]       req_op_a;
    logic [15:0]       req_op_b;
    // Job response
    logic              rsp_valid;
    logic              rsp_ready;
    logic [15:0]       rsp_result;
    logic [CNT_W-1:0]  rsp_cycles;
    logic              rsp_timeout;
    // Core control
    logic              core_reset;
    logic              core_start;
    logic              core_done;
    // Shared data-memory port
    logic              mem_own;
    logic [7:0]        mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_we;
    logic [7:0]        mem_rdata;

    // Sequencer side
    modport slave (
        input  req_valid, req_op_a, req_op_b, rsp_ready, core_done, mem_rdata,
        output req_ready, rsp_valid, rsp_result, rsp_cycles, rsp_timeout,
               core_reset, core_start, mem_own, mem_addr, mem_wdata, mem_we
    );

    // Host / core / memory side
    modport master (
        output req_valid, req_op_a, req_op_b, rsp_ready, core_done, mem_rdata,
        input  req_ready, rsp_valid, rsp_result, rsp_cycles, rsp_timeout,
               core_reset, core_start, mem_own, mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/fp_job_sequencer.sv
// Runs one half-precision add job at a time on the core: reset the core,
// load both operands into its data memory, start it, wait for done (or
// abort on timeout), read the result back and hand it to the requester.
module fp_job_sequencer #(
    parameter logic [7:0]  OPA_ADDR = 8'd8,
    parameter logic [7:0]  OPB_ADDR = 8'd10,
    parameter logic [7:0]  RES_ADDR = 8'd12,
    parameter int unsigned TIMEOUT  = 2000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic               clk,
    input  logic               reset,
    fp_job_sequencer_if.slave  bus
);
    typedef enum logic [3:0] {
        IDLE, CRST, WR0, WR1, WR2, WR3, START, RUN, RD0, RD1, TOUT, RESP
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    state_t            state_q;
    logic [15:0]       op_a_q;
    logic [15:0]       op_b_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [15:0]       result_q;
    logic [CNT_W-1:0]  cycles_q;
    logic              timeout_q;
    logic              rsp_valid_q;
    logic              core_rst_q;
    logic              core_start_q;
    logic              mem_own_q;
    logic              mem_we_q;
    logic [7:0]        mem_addr_q;
    logic [7:0]        mem_wdata_q;

    // RUN-cycle count including the cycle currently ending
    assign cnt_d = cnt_q + CNT_W'(1);

    // Job FSM; every output register is loaded with the value for the state being entered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            op_a_q       <= '0;
            op_b_q       <= '0;
            cnt_q        <= '0;
            result_q     <= '0;
            cycles_q     <= '0;
            timeout_q    <= 1'b0;
            rsp_valid_q  <= 1'b0;
            core_rst_q   <= 1'b0;
            core_start_q <= 1'b0;
            mem_own_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            // Single-cycle strobes and the memory port default to idle values
            core_rst_q   <= 1'b0;
            core_start_q <= 1'b0;
            mem_own_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        op_a_q     <= bus.req_op_a;
                        op_b_q     <= bus.req_op_b;
                        cnt_q      <= '0;
                        timeout_q  <= 1'b0;
                        core_rst_q <= 1'b1;
                        mem_own_q  <= 1'b1;
                        state_q    <= CRST;
                    end
                end
                CRST: begin
                    mem_own_q   <= 1'b1;
                    mem_we_q    <= 1'b1;
                    mem_addr_q  <= OPA_ADDR;
                    mem_wdata_q <= op_a_q[7:0];
                    state_q     <= WR0;
                end
                WR0: begin
                    mem_own_q   <= 1'b1;
                    mem_we_q    <= 1'b1;
                    mem_addr_q  <= OPA_ADDR + 8'd1;
                    mem_wdata_q <= op_a_q[15:8];
                    state_q     <= WR1;
                end
                WR1: begin
                    mem_own_q   <= 1'b1;
                    mem_we_q    <= 1'b1;
                    mem_addr_q  <= OPB_ADDR;
                    mem_wdata_q <= op_b_q[7:0];
                    state_q     <= WR2;
                end
                WR2: begin
                    mem_own_q   <= 1'b1;
                    mem_we_q    <= 1'b1;
                    mem_addr_q  <= OPB_ADDR + 8'd1;
                    mem_wdata_q <= op_b_q[15:8];
                    state_q     <= WR3;
                end
                WR3: begin
                    core_start_q <= 1'b1;
                    state_q      <= START;
                end
                START: begin
                    state_q <= RUN;
                end
                RUN: begin
                    cnt_q <= cnt_d;
                    // Done takes priority over a timeout landing on the same edge
                    if (bus.core_done) begin
                        cycles_q   <= cnt_d;
                        mem_own_q  <= 1'b1;
                        mem_addr_q <= RES_ADDR;
                        state_q    <= RD0;
                    end else if (cnt_d == TIMEOUT_C) begin
                        core_rst_q <= 1'b1;
                        result_q   <= '0;
                        timeout_q  <= 1'b1;
                        cycles_q   <= TIMEOUT_C;
                        state_q    <= TOUT;
                    end
                end
                RD0: begin
                    result_q[7:0] <= bus.mem_rdata;
                    mem_own_q     <= 1'b1;
                    mem_addr_q    <= RES_ADDR + 8'd1;
                    state_q       <= RD1;
                end
                RD1: begin
                    result_q[15:8] <= bus.mem_rdata;
                    rsp_valid_q    <= 1'b1;
                    state_q        <= RESP;
                end
                TOUT: begin
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    // Ready and core reset also follow the reset pin directly so they are correct while it is held
    assign bus.req_ready   = (state_q == IDLE) && !reset;
    assign bus.core_reset  = reset | core_rst_q;
    assign bus.core_start  = core_start_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_result  = result_q;
    assign bus.rsp_cycles  = cycles_q;
    assign bus.rsp_timeout = timeout_q;
    assign bus.mem_own     = mem_own_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.mem_we      = mem_we_q;
endmodule

// File: doc/fp_job_sequencer.md
# fp_job_sequencer

Host-side controller that runs one floating-point add job at a time on the processor core (TopLevel).
- Accepts a pair of 16-bit half-precision operands over a valid/ready request port.
- Resets the core, then writes the operands into the core's byte-wide data memory through a shared port it borrows while the core is idle.
- Pulses start, waits for done or a timeout, then reads back the 16-bit result.
- Returns the result with the run's cycle count over a valid/ready response port.

## Interface
Parameters:
- OPA_ADDR, 8: byte address of operand A LSB (MSB at +1)
- OPB_ADDR, 10: byte address of operand B LSB (MSB at +1)
- RES_ADDR, 12: byte address of result LSB (MSB at +1)
- TIMEOUT, 2000: maximum RUN cycles before abort; must be < 2^CNT_W
- CNT_W, 16: cycle counter width

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- req_valid  in  1  job request
- req_ready  out  1  = (state==IDLE) && !reset
- req_op_a  in  16  operand A, captured at accept edge
- req_op_b  in  16  operand B, captured at accept edge
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_result  out  16  result word
- rsp_cycles  out  CNT_W  RUN-state cycle count
- rsp_timeout  out  1  job aborted by timeout
- core_reset  out  1  core reset
- core_start  out  1  core start pulse
- core_done  in  1  core done flag
- mem_own  out  1  1 = sequencer drives data-memory port, 0 = core owns it
- mem_addr  out  8  memory byte address
- mem_wdata  out  8  write data
- mem_we  out  1  write enable
- mem_rdata  in  8  read data, combinational from mem_addr

## Operation
States: IDLE, CRST, WR0, WR1, WR2, WR3, START, RUN, RD0, RD1, TOUT, RESP.

- **IDLE:** req_ready=1. On req_valid, latch both operands, clear the counter, and go to CRST.
- **CRST:** core_reset=1, mem_own=1. Next state WR0.
- **WR0..WR3:** mem_own=1, mem_we=1. Each state lasts one cycle, then falls through to the next.

  | State | mem_addr | mem_wdata |
  |---|---|---|
  | WR0 | OPA_ADDR | op_a[7:0] |
  | WR1 | OPA_ADDR+1 | op_a[15:8] |
  | WR2 | OPB_ADDR | op_b[7:0] |
  | WR3 | OPB_ADDR+1 | op_b[15:8] |

- **START:** core_start=1 for exactly one cycle, mem_own=0.
- **RUN:** mem_own=0. The counter increments every cycle.
  - core_done high at the edge: capture the counter (including this cycle) into rsp_cycles, go to RD0.
  - Otherwise, counter reaching TIMEOUT: go to TOUT.
  - Done wins if both occur at the same edge.
- **RD0:** mem_own=1, mem_addr=RES_ADDR. Capture mem_rdata into rsp_result[7:0].
- **RD1:** mem_addr=RES_ADDR+1. Capture mem_rdata into rsp_result[15:8], go to RESP.
- **TOUT:** core_reset=1 for one cycle. rsp_result=0, rsp_timeout=1, rsp_cycles=TIMEOUT. Go to RESP.
- **RESP:** rsp_valid=1 with all rsp_* held stable until rsp_ready is seen at an edge, then go to IDLE. rsp_timeout is cleared at the next accept.

Signal rules:
- core_done is ignored outside RUN. A stale high done from a prior run is harmless because CRST resets the core first.
- core_reset = reset | CRST | TOUT.
- mem_we=0 and mem_wdata=0 outside WR states. mem_addr=0 when mem_own=0.

## Timing
Reset values (asynchronous, held while reset=1):
- State: IDLE.
- req_ready=0.
- rsp_valid, rsp_timeout, core_start, mem_own, mem_we = 0.
- mem_addr=0, mem_wdata=0, rsp_result=0, rsp_cycles=0.
- core_reset=1.

Reset mid-job: the state returns to IDLE immediately; the partial job is discarded, with no response.

Latency from the accept edge:
- First RUN cycle is 6 cycles later (CRST + 4 WR + START).
- Normal completion with N RUN cycles: rsp_valid rises 8+N cycles after accept.
- Timeout: rsp_valid rises TIMEOUT+7 cycles after accept.

Throughput:
- The earliest next accept is one cycle after the RESP handshake edge; IDLE lasts at least one cycle.
- One outstanding job at a time; req_ready stays low from accept until IDLE.

## Test plan
1. **Normal run.** Stimulus: req op_a=op_b=0x1A04; memory model has bytes 12=0x04, 13=0x1E; core model raises done 20 cycles after start. Required response:
   - memory writes 8=0x04, 9=0x1A, 10=0x04, 11=0x1A, in that order on consecutive cycles;
   - one core_start pulse;
   - rsp_result=0x1E04, rsp_cycles=20, rsp_timeout=0;
   - rsp_valid 28 cycles after accept.
2. **Timeout.** Stimulus: TIMEOUT=50, core_done never asserted. Required response: core_reset pulses in TOUT; rsp_timeout=1, rsp_result=0x0000, rsp_cycles=50.
3. **Response backpressure.** Stimulus: rsp_ready held low 5 cycles. Required response: rsp_* stable and req_ready=0 throughout; IDLE is entered the cycle after rsp_ready=1.
4. **Stale done.** Stimulus: core_done held high continuously from before the accept. Required response: no effect during IDLE/CRST/WR/START; the first RUN cycle completes with rsp_cycles=1.
5. **Reset mid-RUN.** Stimulus: reset for 2 cycles at RUN cycle 10. Required response: all outputs at reset values, no rsp_valid; a following job (0x3C00, 0x3C00) completes normally.
6. **Back-to-back jobs.** Stimulus: req_valid held high with rsp_ready=1. Required response: the second accept occurs exactly one cycle after the first RESP handshake; operand writes carry the second job's values.
